// File: rtl/gate_input_debouncer_4ch.sv
// gate_input_debouncer_4ch
//
// Purpose: conditions four raw asynchronous inputs (switches, buttons,
// external pins) for the 4-input NAND gate downstream. Each channel is
// synchronized with two flops, debounced by an 8-bit stability counter and
// optionally inverted before driving the gate inputs.
//
// Parameters:
//   DebounceCycles  consecutive enabled cycles the synchronized input must
//                   differ from the held state before it is accepted (1..255)
//   InvertMask      bit n-1 set inverts Output_n
//
// Ports:
//   Clock               design clock, rising edge
//   Reset               synchronous, active-high reset
//   ClockEnable         freezes counters, held state and pulses when low;
//                       the synchronizer flops keep sampling
//   Raw_1..Raw_4        asynchronous raw inputs
//   Output_1..Output_4  debounced level XOR InvertMask bit
//   Changed_1..4        one-cycle pulse when a channel's held state flips
//   Stable              every counter idle and no change pending

module gate_input_debouncer_4ch #(
    parameter int unsigned DebounceCycles = 4,
    parameter logic [3:0]  InvertMask     = 4'b0000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic ClockEnable,
    input  logic Raw_1,
    input  logic Raw_2,
    input  logic Raw_3,
    input  logic Raw_4,
    output logic Output_1,
    output logic Output_2,
    output logic Output_3,
    output logic Output_4,
    output logic Changed_1,
    output logic Changed_2,
    output logic Changed_3,
    output logic Changed_4,
    output logic Stable
);

    localparam logic [7:0] CntLast = 8'(DebounceCycles - 1);

    logic [3:0] raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] state_q, state_d;
    logic [3:0] chg_q, chg_d;
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];
    logic [3:0] settled;

    assign raw = {Raw_4, Raw_3, Raw_2, Raw_1};

    // Any cycle where the synchronized input matches the held state clears
    // the counter, so glitches never accumulate toward an accept.
    always_comb begin
        state_d = state_q;
        chg_d   = '0;
        for (int ch = 0; ch < 4; ch++) begin
            cnt_d[ch] = cnt_q[ch];
        end
        if (ClockEnable) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (sync2_q[ch] == state_q[ch]) begin
                    cnt_d[ch] = '0;
                end else if (cnt_q[ch] == CntLast) begin
                    state_d[ch] = sync2_q[ch];
                    cnt_d[ch]   = '0;
                    chg_d[ch]   = 1'b1;
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= '0;
            chg_q   <= '0;
            for (int ch = 0; ch < 4; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            // Synchronizer runs every edge, independent of ClockEnable.
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            chg_q   <= chg_d;
            for (int ch = 0; ch < 4; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    always_comb begin
        settled = '0;
        for (int ch = 0; ch < 4; ch++) begin
            settled[ch] = (cnt_q[ch] == 8'd0) && (sync2_q[ch] == state_q[ch]);
        end
    end

    assign Output_1  = state_q[0] ^ InvertMask[0];
    assign Output_2  = state_q[1] ^ InvertMask[1];
    assign Output_3  = state_q[2] ^ InvertMask[2];
    assign Output_4  = state_q[3] ^ InvertMask[3];
    assign Changed_1 = chg_q[0];
    assign Changed_2 = chg_q[1];
    assign Changed_3 = chg_q[2];
    assign Changed_4 = chg_q[3];
    assign Stable    = &settled;

endmodule

// File: tb/tb_gate_input_debouncer_4ch.sv
// Testbench for gate_input_debouncer_4ch: directed timing checks plus a
// randomized run compared against a sample-window reference model.

module tb_gate_input_debouncer_4ch;

    localparam int unsigned D    = 4;
    localparam logic [3:0]  MASK = 4'b0101;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] raw;

    logic Output_1, Output_2, Output_3, Output_4;
    logic Changed_1, Changed_2, Changed_3, Changed_4;
    logic Stable;

    logic [3:0] dut_out;
    logic [3:0] dut_chg;

    int nchk = 0;
    int nerr = 0;

    // Reference model: a channel accepts the opposite level once its last
    // D enabled-cycle samples of the synchronized input all disagree with
    // the held level. The window is discarded on accept and on reset.
    logic [3:0] m_s1, m_s2, m_held, m_chg;
    bit         hist [4][$];

    always #5 clk = ~clk;

    gate_input_debouncer_4ch #(
        .DebounceCycles(D),
        .InvertMask    (MASK)
    ) dut (
        .Clock      (clk),
        .Reset      (rst),
        .ClockEnable(en),
        .Raw_1      (raw[0]),
        .Raw_2      (raw[1]),
        .Raw_3      (raw[2]),
        .Raw_4      (raw[3]),
        .Output_1   (Output_1),
        .Output_2   (Output_2),
        .Output_3   (Output_3),
        .Output_4   (Output_4),
        .Changed_1  (Changed_1),
        .Changed_2  (Changed_2),
        .Changed_3  (Changed_3),
        .Changed_4  (Changed_4),
        .Stable     (Stable)
    );

    assign dut_out = {Output_4, Output_3, Output_2, Output_1};
    assign dut_chg = {Changed_4, Changed_3, Changed_2, Changed_1};

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic void model_edge();
        bool_flip_loop: for (int c = 0; c < 4; c++) begin
            if (rst) begin
                hist[c].delete();
                m_chg[c] = 1'b0;
                m_held[c] = 1'b0;
            end else if (en) begin
                bit all_diff;
                hist[c].push_back(m_s2[c]);
                if (hist[c].size() > D) void'(hist[c].pop_front());
                all_diff = (hist[c].size() == D);
                foreach (hist[c][i]) if (hist[c][i] == m_held[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_held[c] = ~m_held[c];
                    m_chg[c]  = 1'b1;
                    hist[c].delete();
                end else begin
                    m_chg[c] = 1'b0;
                end
            end else begin
                m_chg[c] = 1'b0;
            end
        end
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
        end else begin
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endfunction

    function automatic logic model_stable();
        logic s = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (m_s2[c] != m_held[c]) s = 1'b0;
            if (hist[c].size() != 0 && hist[c][hist[c].size()-1] != m_held[c]) s = 1'b0;
        end
        return s;
    endfunction

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, " model out"}, dut_out, m_held ^ MASK);
        chk({tag, " model chg"}, dut_chg, m_chg);
        chk({tag, " model stable"}, {3'b000, Stable}, {3'b000, model_stable()});
    endtask

    initial begin
        m_s1 = '0; m_s2 = '0; m_held = '0; m_chg = '0;
        rst = 1'b1; en = 1'b1; raw = '0;

        // Reset state
        cycle("reset");
        cycle("reset");
        chk("reset out", dut_out, 4'b0101);
        chk("reset chg", dut_chg, 4'b0000);
        chk("reset stable", {3'b000, Stable}, 4'b0001);
        rst = 1'b0;
        cycle("idle");

        // Raw_1 rises before edge E; accepted at E+5
        raw[0] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            cycle("ch1 rise");
            chk("ch1 out", {3'b000, Output_1}, (k >= 5) ? 4'd0 : 4'd1);
            chk("ch1 chg", {3'b000, Changed_1}, (k == 5) ? 4'd1 : 4'd0);
            chk("ch1 stable", {3'b000, Stable}, (k >= 1 && k <= 4) ? 4'd0 : 4'd1);
        end

        // Raw_2 glitch of 3 cycles is discarded
        raw[1] = 1'b1;
        for (int k = 0; k < 3; k++) cycle("ch2 glitch");
        raw[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle("ch2 glitch");
            chk("ch2 out", {3'b000, Output_2}, 4'd0);
            chk("ch2 chg", {3'b000, Changed_2}, 4'd0);
        end
        chk("ch2 stable", {3'b000, Stable}, 4'd1);

        // All four channels toggle together
        raw = ~raw;
        for (int k = 0; k <= 6; k++) begin
            cycle("all toggle");
            chk("all out", dut_out, (k >= 5) ? 4'b1011 : 4'b0100);
            chk("all chg", dut_chg, (k == 5) ? 4'b1111 : 4'b0000);
        end
        for (int k = 0; k < 3; k++) cycle("settle");

        // ClockEnable low for two cycles mid-count on Raw_3
        raw[2] = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            en = !(k == 3 || k == 4);
            cycle("ch3 enable");
            chk("ch3 out", {3'b000, Output_3}, (k >= 7) ? 4'd1 : 4'd0);
            chk("ch3 chg", {3'b000, Changed_3}, (k == 7) ? 4'd1 : 4'd0);
        end
        en = 1'b1;

        // Reset mid-count on Raw_4, then recount from scratch
        rst = 1'b1; raw = '0;
        cycle("pre reset");
        rst = 1'b0;
        cycle("pre reset");
        cycle("pre reset");
        raw[3] = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            cycle("ch4 count");
            chk("ch4 pre out", {3'b000, Output_4}, 4'd0);
        end
        rst = 1'b1;
        cycle("ch4 reset");
        chk("ch4 reset out", dut_out, 4'b0101);
        chk("ch4 reset chg", dut_chg, 4'b0000);
        chk("ch4 reset stable", {3'b000, Stable}, 4'd1);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cycle("ch4 recount");
            chk("ch4 out", {3'b000, Output_4}, (k >= 6) ? 4'd1 : 4'd0);
            chk("ch4 chg", {3'b000, Changed_4}, (k == 6) ? 4'd1 : 4'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            en  = ($urandom_range(0, 99) < 85);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 6) == 0) raw[c] = ~raw[c];
            end
            cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
